// File: rtl/sdc_pkg.sv
// Shared definitions for the serial distance calculator: FSM encoding, default widths
// and helpers for the widened numerator width and the end-to-end latency.
package sdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV_R1,
    S_DIV_R2,
    S_MUL,
    S_DIV_ST,
    S_DONE
  } state_t;

  localparam int WORD_WIDTH_DEF = 8;
  localparam int DIST_WIDTH_DEF = 7;
  localparam int MAX_C_SIZE_DEF = 128;

  function automatic int num_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int latency_cycles(input int w);
    return 4 * w + 3;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; i_len iterations, the first
// performed on the start edge. o_done pulses the cycle after the final iteration.
module serial_divider #(
  parameter int N          = 17,
  parameter int WORD_WIDTH = 8,
  localparam int CW        = $clog2(N + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [N-1:0]          i_dividend,
  input  logic [WORD_WIDTH-1:0] i_divisor,
  input  logic [CW-1:0]         i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [N-1:0]          o_quotient,
  output logic [WORD_WIDTH-1:0] o_remainder
);

  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [WORD_WIDTH-1:0] r_rem;
  logic [N-1:0]          r_quo;
  logic [WORD_WIDTH-1:0] r_div;
  logic [CW-1:0]         r_cnt;
  logic                  r_busy;
  logic                  r_done;

  logic [WORD_WIDTH-1:0] w_rem_src;
  logic [N-1:0]          w_quo_src;
  logic [WORD_WIDTH-1:0] w_div;
  logic [WORD_WIDTH:0]   w_trial;
  logic                  w_ge;
  logic [WORD_WIDTH-1:0] w_diff;
  logic [WORD_WIDTH-1:0] w_rem_nxt;
  logic [N-1:0]          w_quo_nxt;

  assign w_rem_src = i_start ? '0 : r_rem;
  assign w_quo_src = i_start ? i_dividend : r_quo;
  assign w_div     = i_start ? i_divisor : r_div;
  assign w_trial   = {w_rem_src, w_quo_src[N-1]};
  assign w_ge      = w_trial >= {1'b0, w_div};
  // Only taken when trial >= divisor, so the low bits hold the exact difference.
  assign w_diff    = w_trial[WORD_WIDTH-1:0] - w_div;
  assign w_rem_nxt = w_ge ? w_diff : w_trial[WORD_WIDTH-1:0];
  assign w_quo_nxt = {w_quo_src[N-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_rem_nxt;
        r_quo  <= w_quo_nxt;
        r_div  <= i_divisor;
        r_cnt  <= i_len - ONE_C;
        r_busy <= i_len > ONE_C;
        r_done <= i_len == ONE_C;
      end else if (r_busy) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt - ONE_C;
        if (r_cnt == ONE_C) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/serial_distance_calculator.sv
// Serial redundancy distance ((ow-fw)*(idx2/fw-idx1/fw)+(idx2-idx1))/st over one shared divider;
// result 4*WORD_WIDTH+3 edges after accept, held until out_ready. SDC_EXCEPT_MASK_EN adds the except mask.
module serial_distance_calculator
  import sdc_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
`ifdef SDC_EXCEPT_MASK_EN
  parameter int MAX_C_SIZE = MAX_C_SIZE_DEF,
`endif
  parameter int DIST_WIDTH = DIST_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] idx1,
  input  logic [WORD_WIDTH-1:0] idx2,
  input  logic [WORD_WIDTH-1:0] ow,
  input  logic [WORD_WIDTH-1:0] fw,
  input  logic [WORD_WIDTH-1:0] st,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIST_WIDTH-1:0] dr,
  output logic                  exact,
`ifdef SDC_EXCEPT_MASK_EN
  output logic [MAX_C_SIZE-1:0] except,
`endif
  output logic                  err
);

  localparam int NUM_W = num_w(WORD_WIDTH);
  localparam int CW    = $clog2(NUM_W + 1);
  localparam int PAD   = NUM_W - WORD_WIDTH;
  localparam logic [CW-1:0]    LEN_SHORT = CW'(WORD_WIDTH);
  localparam logic [CW-1:0]    LEN_LONG  = CW'(NUM_W);
  localparam logic [NUM_W-1:0] DR_MAX    = NUM_W'((1 << DIST_WIDTH) - 1);

  state_t r_state, w_next;

  logic [WORD_WIDTH-1:0] r_idx1, r_idx2, r_ow, r_fw, r_st, r_r1, r_r2;
  logic                  r_out_valid, r_exact, r_err;
  logic [DIST_WIDTH-1:0] r_dr;

  logic                  w_accept, w_in_err;
  logic                  w_div_start, w_div_busy, w_div_done;
  logic [NUM_W-1:0]      w_div_dividend, w_div_quo;
  logic [WORD_WIDTH-1:0] w_div_divisor, w_div_rem;
  logic [CW-1:0]         w_div_len;
  logic [NUM_W-1:0]      w_span, w_rows, w_num;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;
  assign w_in_err = (fw == '0) | (st == '0) | (ow < fw) | (idx2 < idx1);

  assign w_span = {{PAD{1'b0}}, r_ow - r_fw};
  assign w_rows = {{PAD{1'b0}}, r_r2 - r_r1};
  assign w_num  = w_span * w_rows + {{PAD{1'b0}}, r_idx2 - r_idx1};

  // Short divisions left-align the index so the same N-bit shifter serves all three.
  always_comb begin
    w_next         = r_state;
    w_div_start    = 1'b0;
    w_div_dividend = {r_idx2, {PAD{1'b0}}};
    w_div_divisor  = r_fw;
    w_div_len      = LEN_SHORT;
    case (r_state)
      S_IDLE: begin
        w_div_dividend = {idx1, {PAD{1'b0}}};
        w_div_divisor  = fw;
        if (w_accept) begin
          if (w_in_err) begin
            w_next = S_DONE;
          end else begin
            w_div_start = 1'b1;
            w_next      = S_DIV_R1;
          end
        end
      end
      S_DIV_R1: begin
        if (w_div_done) begin
          w_div_start = 1'b1;
          w_next      = S_DIV_R2;
        end
      end
      S_DIV_R2: if (w_div_done) w_next = S_MUL;
      S_MUL: begin
        w_div_dividend = w_num;
        w_div_divisor  = r_st;
        w_div_len      = LEN_LONG;
        w_div_start    = !w_div_busy;
        if (!w_div_busy) w_next = S_DIV_ST;
      end
      S_DIV_ST: if (w_div_done) w_next = S_DONE;
      S_DONE:   if (r_out_valid && out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx1      <= '0;
      r_idx2      <= '0;
      r_ow        <= '0;
      r_fw        <= '0;
      r_st        <= '0;
      r_r1        <= '0;
      r_r2        <= '0;
      r_out_valid <= 1'b0;
      r_dr        <= '0;
      r_exact     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_accept) begin
        r_idx1 <= idx1;
        r_idx2 <= idx2;
        r_ow   <= ow;
        r_fw   <= fw;
        r_st   <= st;
        if (w_in_err) begin
          r_err   <= 1'b1;
          r_dr    <= '0;
          r_exact <= 1'b0;
        end
      end
      if (r_state == S_DIV_R1 && w_div_done) r_r1 <= w_div_quo[WORD_WIDTH-1:0];
      if (r_state == S_DIV_R2 && w_div_done) r_r2 <= w_div_quo[WORD_WIDTH-1:0];
      if (r_state == S_DIV_ST && w_div_done) begin
        if (w_div_quo > DR_MAX) begin
          r_err   <= 1'b1;
          r_dr    <= '0;
          r_exact <= 1'b0;
        end else begin
          r_err   <= 1'b0;
          r_dr    <= w_div_quo[DIST_WIDTH-1:0];
          r_exact <= (w_div_rem == '0);
        end
      end
      if (r_state == S_DONE) begin
        if (!r_out_valid) begin
          r_out_valid <= 1'b1;
        end else if (out_ready) begin
          r_out_valid <= 1'b0;
          r_dr        <= '0;
          r_exact     <= 1'b0;
          r_err       <= 1'b0;
        end
      end
    end
  end

`ifdef SDC_EXCEPT_MASK_EN
  localparam logic [MAX_C_SIZE-1:0] MASK_ONE = MAX_C_SIZE'(1);
  logic [MAX_C_SIZE-1:0] r_except;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_except <= '0;
    end else if (r_state == S_DONE) begin
      if (!r_out_valid)
        r_except <= (r_exact && (int'(r_dr) < MAX_C_SIZE)) ? (MASK_ONE << r_dr) : '0;
      else if (out_ready)
        r_except <= '0;
    end
  end

  assign except = r_except;
`endif

  serial_divider #(.N(NUM_W), .WORD_WIDTH(WORD_WIDTH)) u_div (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_div_start),
    .i_dividend  (w_div_dividend),
    .i_divisor   (w_div_divisor),
    .i_len       (w_div_len),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_div_quo),
    .o_remainder (w_div_rem)
  );

  assign out_valid = r_out_valid;
  assign dr        = r_dr;
  assign exact     = r_exact;
  assign err       = r_err;

endmodule

// File: tb/tb_serial_distance_calculator.sv
// Directed bench for serial_distance_calculator: hand-computed distances, latency, errors,
// backpressure and mid-operation reset.
module tb_serial_distance_calculator;

  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready;
  logic [7:0] idx1, idx2, ow, fw, st;
  logic       in_ready, out_valid, exact, err;
  logic [6:0] dr;
`ifdef SDC_EXCEPT_MASK_EN
  logic [127:0] except;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_distance_calculator dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .idx1      (idx1),
    .idx2      (idx2),
    .ow        (ow),
    .fw        (fw),
    .st        (st),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dr        (dr),
    .exact     (exact),
`ifdef SDC_EXCEPT_MASK_EN
    .except    (except),
`endif
    .err       (err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] a_ow, a_fw, a_st, a_i1, a_i2);
    ow = a_ow; fw = a_fw; st = a_st; idx1 = a_i1; idx2 = a_i2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ow = 8'h01; fw = 8'h00; st = 8'h00; idx1 = 8'hff; idx2 = 8'h00;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov_after"}, out_valid, 1'b0);
    chk({tag, "_rdy_after"}, in_ready, 1'b1);
  endtask

  task automatic run(input string tag, input logic [7:0] a_ow, a_fw, a_st, a_i1, a_i2,
                     input int lat, input logic [6:0] e_dr, input logic e_ex, input logic e_er);
    int cyc;
    chk({tag, "_rdy"}, in_ready, 1'b1);
    accept(a_ow, a_fw, a_st, a_i1, a_i2);
    wait_out(cyc);
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_dr"}, dr, e_dr);
    chk({tag, "_exact"}, exact, e_ex);
    chk({tag, "_err"}, err, e_er);
`ifdef SDC_EXCEPT_MASK_EN
    begin
      logic [127:0] e_x;
      e_x = e_ex ? (128'd1 << e_dr) : 128'd0;
      chk({tag, "_except"}, except, e_x);
    end
`endif
    handoff(tag);
  endtask

  initial begin
    int cyc;
    int seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    idx1 = '0; idx2 = '0; ow = '0; fw = '0; st = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_dr", dr, 7'd0);
    chk("rst_exact", exact, 1'b0);
    chk("rst_err", err, 1'b0);
`ifdef SDC_EXCEPT_MASK_EN
    chk("rst_except", except, 128'd0);
`endif

    run("c1",    8'd20,  8'd3, 8'd1, 8'd0,  8'd4,   35, 7'd21,  1'b1, 1'b0);
    run("c2",    8'd42,  8'd5, 8'd2, 8'd0,  8'd12,  35, 7'd43,  1'b1, 1'b0);
    run("c3",    8'd20,  8'd5, 8'd5, 8'd0,  8'd4,   35, 7'd0,   1'b0, 1'b0);
    run("c4",    8'd200, 8'd2, 8'd1, 8'd0,  8'd200, 35, 7'd0,   1'b0, 1'b1);
    run("r1nz",  8'd10,  8'd3, 8'd3, 8'd4,  8'd10,  35, 7'd6,   1'b0, 1'b0);
    run("same",  8'd10,  8'd3, 8'd2, 8'd7,  8'd7,   35, 7'd0,   1'b1, 1'b0);
    run("q127",  8'd127, 8'd1, 8'd1, 8'd0,  8'd1,   35, 7'd127, 1'b1, 1'b0);
    run("q128",  8'd128, 8'd1, 8'd1, 8'd0,  8'd1,   35, 7'd0,   1'b0, 1'b1);
    run("fw0",   8'd20,  8'd0, 8'd1, 8'd0,  8'd4,   1,  7'd0,   1'b0, 1'b1);
    run("st0",   8'd20,  8'd3, 8'd0, 8'd0,  8'd4,   1,  7'd0,   1'b0, 1'b1);
    run("idxlt", 8'd20,  8'd3, 8'd1, 8'd9,  8'd4,   1,  7'd0,   1'b0, 1'b1);
    run("owlt",  8'd2,   8'd3, 8'd1, 8'd0,  8'd4,   1,  7'd0,   1'b0, 1'b1);

    // Backpressure: result must hold while out_ready stays low.
    accept(8'd20, 8'd3, 8'd1, 8'd0, 8'd4);
    wait_out(cyc);
    chk("bp_lat", cyc, 35);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("bp_ov_held", out_valid, 1'b1);
    chk("bp_dr_held", dr, 7'd21);
    chk("bp_exact_held", exact, 1'b1);
    chk("bp_in_ready", in_ready, 1'b0);
    handoff("bp");

    // Reset during the second index division aborts the request.
    accept(8'd42, 8'd5, 8'd2, 8'd0, 8'd12);
    repeat (12) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1;
    end
    chk("midrst_no_out", seen, 0);
    chk("midrst_in_ready", in_ready, 1'b1);
    run("after_rst", 8'd42, 8'd5, 8'd2, 8'd0, 8'd12, 35, 7'd43, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
